// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the staged reset sequencer.
// Imported by reset_seq and seq_timer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RELEASE,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  function automatic int ctr_w(input int term);
    return (term < 1) ? 1 : $clog2(term + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
// Shared by the hold period and the per-stage ack timeout.
module seq_timer #(
  parameter int W = 5
) (
  input  logic         clk_slow,
  input  logic         reset_in,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk_slow) begin
    if (!reset_in) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/reset_seq.sv
// Releases NUM_STAGES reset domains in order after lock, one ack at a time,
// with bounded retries and a sticky fault.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 1024,
  parameter int RETRY_MAX   = 3,
  localparam int SW = idx_w(NUM_STAGES),
  localparam int RW = ctr_w(RETRY_MAX)
) (
  input  logic                  clk_slow,
  input  logic                  reset_in,
  input  logic                  lock_in,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  all_ready,
  output logic                  fault,
  output logic [SW-1:0]         fault_stage,
  output logic [RW-1:0]         retry_cnt
);

  localparam int TW = ctr_w(max2(HOLD_CYCLES, ACK_TIMEOUT) - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LD  = TW'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0] LAST    = SW'(NUM_STAGES - 1);
  localparam logic [RW-1:0] RMAX    = RW'(RETRY_MAX);

  state_t state, state_n;

  logic [SW-1:0]         idx, idx_n, tmo_stage;
  logic [NUM_STAGES-1:0] rst_d;
  logic                  rdy_d, flt_d, tmo;
  logic [SW-1:0]         fs_d;
  logic [RW-1:0]         rc_d;
  logic                  tmr_load, tmr_en, tmr_done;
  logic [TW-1:0]         tmr_val;

  // Release mask for stages 0..i keeps stage_rst_n monotonic by construction.
  function automatic logic [NUM_STAGES-1:0] upto(input logic [SW-1:0] i);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      m[k] = (k <= int'(i));
    end
    return m;
  endfunction

  seq_timer #(
    .W(TW)
  ) u_timer (
    .clk_slow (clk_slow),
    .reset_in (reset_in),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    rst_d     = stage_rst_n;
    rdy_d     = all_ready;
    flt_d     = fault;
    fs_d      = fault_stage;
    rc_d      = retry_cnt;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = HOLD_LD;
    tmo       = 1'b0;
    tmo_stage = idx;

    unique case (state)
      IDLE: begin
        rst_d = '0;
        rdy_d = 1'b0;
        if (lock_in) begin
          state_n  = HOLD;
          tmr_load = 1'b1;
        end
      end
      HOLD: begin
        tmr_en = 1'b1;
        if (!lock_in) begin
          state_n = IDLE;
        end else if (tmr_done) begin
          state_n = RELEASE;
          idx_n   = '0;
          rst_d   = upto('0);
        end
      end
      RELEASE: begin
        if (!lock_in) begin
          state_n = IDLE;
        end else begin
          state_n  = WAIT_ACK;
          tmr_load = 1'b1;
          tmr_val  = ACK_LD;
        end
      end
      WAIT_ACK: begin
        tmr_en = 1'b1;
        if (!lock_in) begin
          state_n = IDLE;
        end else if (stage_ack[idx]) begin
          if (idx == LAST) begin
            state_n = DONE;
            rdy_d   = 1'b1;
            rc_d    = '0;
          end else begin
            state_n = RELEASE;
            idx_n   = idx + 1'b1;
            rst_d   = upto(idx + 1'b1);
          end
        end else if (tmr_done) begin
          tmo = 1'b1;
        end
      end
      DONE: begin
        if (!lock_in) begin
          state_n = IDLE;
        end else if (!(&stage_ack)) begin
          tmo = 1'b1;
          for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (!stage_ack[k]) tmo_stage = SW'(k);
          end
        end
      end
      FAULT: begin
        rst_d = '0;
        rdy_d = 1'b0;
        flt_d = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (state_n == IDLE) begin
      rst_d = '0;
      rdy_d = 1'b0;
    end

    if (tmo) begin
      rst_d = '0;
      rdy_d = 1'b0;
      fs_d  = tmo_stage;
      rc_d  = retry_cnt + 1'b1;
      if (rc_d == RMAX) begin
        state_n = FAULT;
        flt_d   = 1'b1;
      end else begin
        state_n  = HOLD;
        tmr_load = 1'b1;
        tmr_val  = HOLD_LD;
      end
    end
  end

  always_ff @(posedge clk_slow) begin
    if (!reset_in) begin
      state       <= IDLE;
      idx         <= '0;
      stage_rst_n <= '0;
      all_ready   <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
      retry_cnt   <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      stage_rst_n <= rst_d;
      all_ready   <= rdy_d;
      fault       <= flt_d;
      fault_stage <= fs_d;
      retry_cnt   <= rc_d;
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Directed table-driven bench for reset_seq (3 stages, hold 16,
// ack timeout 32, 2 retries) plus hand-written corner sequences.
module tb_reset_seq;

  logic       clk_slow  = 1'b0;
  logic       reset_in  = 1'b0;
  logic       lock_in   = 1'b0;
  logic [2:0] stage_ack = 3'b000;
  logic [2:0] stage_rst_n;
  logic       all_ready;
  logic       fault;
  logic [1:0] fault_stage;
  logic [1:0] retry_cnt;

  reset_seq #(
    .NUM_STAGES  (3),
    .HOLD_CYCLES (16),
    .ACK_TIMEOUT (32),
    .RETRY_MAX   (2)
  ) dut (
    .clk_slow    (clk_slow),
    .reset_in    (reset_in),
    .lock_in     (lock_in),
    .stage_ack   (stage_ack),
    .stage_rst_n (stage_rst_n),
    .all_ready   (all_ready),
    .fault       (fault),
    .fault_stage (fault_stage),
    .retry_cnt   (retry_cnt)
  );

  always #5 clk_slow = ~clk_slow;

  typedef struct {
    logic       rst;
    logic       lock;
    logic [2:0] ack;
    int         n;
    logic [2:0] e_rst;
    logic       e_rdy;
    logic       e_flt;
    logic [1:0] e_fs;
    logic [1:0] e_rc;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_slow);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [2:0] er,
                       input logic erdy, input logic eflt,
                       input logic [1:0] efs, input logic [1:0] erc);
    total++;
    if ({stage_rst_n, all_ready, fault, fault_stage, retry_cnt}
        === {er, erdy, eflt, efs, erc}) begin
      passed++;
    end else begin
      $display("FAIL %s: got rst_n=%b rdy=%b flt=%b fs=%0d rc=%0d, want rst_n=%b rdy=%b flt=%b fs=%0d rc=%0d",
               name, stage_rst_n, all_ready, fault, fault_stage, retry_cnt,
               er, erdy, eflt, efs, erc);
    end
  endtask

  function automatic void add(input logic r, input logic l,
                              input logic [2:0] a, input int n,
                              input logic [2:0] er, input logic erdy,
                              input logic eflt, input logic [1:0] efs,
                              input logic [1:0] erc);
    vec_t v;
    v.rst = r; v.lock = l; v.ack = a; v.n = n;
    v.e_rst = er; v.e_rdy = erdy; v.e_flt = eflt;
    v.e_fs = efs; v.e_rc = erc;
    vecs.push_back(v);
  endfunction

  initial begin
    // reset, then normal sequence with acks 3 cycles after each release
    add(0, 0, 3'b000,  2, 3'b000, 0, 0, 0, 0);
    add(1, 0, 3'b000,  3, 3'b000, 0, 0, 0, 0);
    add(1, 1, 3'b000, 16, 3'b000, 0, 0, 0, 0);
    add(1, 1, 3'b000,  1, 3'b001, 0, 0, 0, 0);
    add(1, 1, 3'b000,  3, 3'b001, 0, 0, 0, 0);
    add(1, 1, 3'b001,  1, 3'b011, 0, 0, 0, 0);
    add(1, 1, 3'b001,  3, 3'b011, 0, 0, 0, 0);
    add(1, 1, 3'b011,  1, 3'b111, 0, 0, 0, 0);
    add(1, 1, 3'b011,  3, 3'b111, 0, 0, 0, 0);
    add(1, 1, 3'b111,  1, 3'b111, 1, 0, 0, 0);
    add(1, 1, 3'b111,  5, 3'b111, 1, 0, 0, 0);
    // ack[2] drops in DONE, then resequence with acks held high
    add(1, 1, 3'b011,  1, 3'b000, 0, 0, 2, 1);
    add(1, 1, 3'b111, 15, 3'b000, 0, 0, 2, 1);
    add(1, 1, 3'b111,  1, 3'b001, 0, 0, 2, 1);
    add(1, 1, 3'b111,  1, 3'b001, 0, 0, 2, 1);
    add(1, 1, 3'b111,  1, 3'b011, 0, 0, 2, 1);
    add(1, 1, 3'b111,  1, 3'b011, 0, 0, 2, 1);
    add(1, 1, 3'b111,  1, 3'b111, 0, 0, 2, 1);
    add(1, 1, 3'b111,  1, 3'b111, 0, 0, 2, 1);
    add(1, 1, 3'b111,  1, 3'b111, 1, 0, 2, 0);
    // reset outranks lock; lock loss in WAIT_ACK(1); relock
    add(0, 1, 3'b111,  1, 3'b000, 0, 0, 0, 0);
    add(1, 1, 3'b000, 17, 3'b001, 0, 0, 0, 0);
    add(1, 1, 3'b001,  2, 3'b011, 0, 0, 0, 0);
    add(1, 1, 3'b001,  1, 3'b011, 0, 0, 0, 0);
    add(1, 0, 3'b001,  1, 3'b000, 0, 0, 0, 0);
    add(1, 0, 3'b001,  3, 3'b000, 0, 0, 0, 0);
    add(1, 1, 3'b000, 16, 3'b000, 0, 0, 0, 0);
    add(1, 1, 3'b000,  1, 3'b001, 0, 0, 0, 0);
    // stage 1 never acks: two timeouts then fault
    add(1, 1, 3'b001,  2, 3'b011, 0, 0, 0, 0);
    add(1, 1, 3'b001, 32, 3'b011, 0, 0, 0, 0);
    add(1, 1, 3'b001,  1, 3'b000, 0, 0, 1, 1);
    add(1, 1, 3'b001, 16, 3'b001, 0, 0, 1, 1);
    add(1, 1, 3'b001,  2, 3'b011, 0, 0, 1, 1);
    add(1, 1, 3'b001, 32, 3'b011, 0, 0, 1, 1);
    add(1, 1, 3'b001,  1, 3'b000, 0, 1, 1, 2);
    add(1, 1, 3'b001, 40, 3'b000, 0, 1, 1, 2);
    add(1, 0, 3'b111,  3, 3'b000, 0, 1, 1, 2);
    add(0, 0, 3'b111,  1, 3'b000, 0, 0, 0, 0);

    #2;
    foreach (vecs[i]) begin
      reset_in  = vecs[i].rst;
      lock_in   = vecs[i].lock;
      stage_ack = vecs[i].ack;
      step(vecs[i].n);
      check($sformatf("row%0d", i), vecs[i].e_rst, vecs[i].e_rdy,
            vecs[i].e_flt, vecs[i].e_fs, vecs[i].e_rc);
    end

    // one-cycle reset in the middle of HOLD restarts the full hold
    reset_in = 1'b1; lock_in = 1'b1; stage_ack = 3'b000;
    step(5);
    check("hold_mid", 3'b000, 0, 0, 0, 0);
    reset_in = 1'b0;
    step(1);
    check("rst_hold", 3'b000, 0, 0, 0, 0);
    reset_in = 1'b1;
    step(16);
    check("rehold_pre", 3'b000, 0, 0, 0, 0);
    step(1);
    check("rehold_rel", 3'b001, 0, 0, 0, 0);

    // ack arriving on the timeout terminal cycle wins
    step(32);
    check("pre_term", 3'b001, 0, 0, 0, 0);
    stage_ack = 3'b001;
    step(1);
    check("ack_wins", 3'b011, 0, 0, 0, 0);

    // lock loss outranks a simultaneous ack
    step(1);
    check("wait1", 3'b011, 0, 0, 0, 0);
    lock_in = 1'b0; stage_ack = 3'b011;
    step(1);
    check("lock_wins", 3'b000, 0, 0, 0, 0);

    // acks tied high before lock: one release per two cycles
    stage_ack = 3'b111;
    step(2);
    check("idle_acks", 3'b000, 0, 0, 0, 0);
    lock_in = 1'b1;
    step(17);
    check("tied_r0", 3'b001, 0, 0, 0, 0);
    step(1);
    check("tied_w0", 3'b001, 0, 0, 0, 0);
    step(1);
    check("tied_r1", 3'b011, 0, 0, 0, 0);
    step(2);
    check("tied_r2", 3'b111, 0, 0, 0, 0);
    step(2);
    check("tied_done", 3'b111, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Consumer side of the reset generator: takes the global lock/enable and releases NUM_STAGES downstream reset domains in a fixed order, all on one clock.
- Each released stage must return a ready acknowledge before the next stage is released.
- Missing acknowledges are retried a bounded number of times, then a sticky fault is reported.
- Sits between the PLL-lock/reset generator and the ADC capture, AXIS packer and DMA-facing logic of the axis_ad7276 IP.

Parameters:
- NUM_STAGES, 3, number of sequenced reset domains (>=1).
- HOLD_CYCLES, 16, cycles all stages stay in reset after lock before stage 0 is released (>=1).
- ACK_TIMEOUT, 1024, cycles allowed per stage for stage_ack after its release (>=2).
- RETRY_MAX, 3, full re-sequencing attempts before fault (>=1).

Ports:
- clk_slow  in  1  sole clock; all logic on rising edge.
- reset_in  in  1  synchronous, active-low reset.
- lock_in  in  1  upstream lock/enable; high = clock stable.
- stage_ack  in  NUM_STAGES  per-stage ready acknowledge; level, not pulse.
- stage_rst_n  out  NUM_STAGES  per-stage reset, active low.
- all_ready  out  1  high while every stage is released and acknowledged.
- fault  out  1  sticky; retries exhausted.
- fault_stage  out  $clog2(NUM_STAGES) (min 1)  index of the stage whose last timeout caused the fault.
- retry_cnt  out  $clog2(RETRY_MAX+1)  attempts failed so far.

Behaviour:
- Reset (reset_in=0 sampled at an edge):
  - State=IDLE; stage_rst_n=all 0; all_ready=0; fault=0; fault_stage=0; retry_cnt=0; counters=0.
- IDLE:
  - All stages held in reset.
  - lock_in=1 sampled at cycle t -> HOLD at t+1 with hold counter cleared.
- HOLD:
  - Counts 0..HOLD_CYCLES-1.
  - On the terminal count -> RELEASE(0). stage_rst_n[0] goes 1 exactly HOLD_CYCLES cycles after HOLD entry.
- RELEASE(i):
  - Registers stage_rst_n[i]=1 (stages <i stay 1) and enters WAIT_ACK(i) with the timeout counter cleared.
- WAIT_ACK(i):
  - stage_ack[i] is sampled only here; ack before release is ignored. An ack already high is accepted on the first WAIT_ACK cycle.
  - Ack=1 at cycle a: if i<NUM_STAGES-1, stage_rst_n[i+1]=1 at a+1. If i is the last stage -> DONE, all_ready=1 at a+1.
  - Timeout counter reaches ACK_TIMEOUT-1 without ack -> timeout event.
- Timeout event:
  - All stage_rst_n driven 0 next cycle; retry_cnt+1; fault_stage=i.
  - If the new retry_cnt==RETRY_MAX -> FAULT, otherwise -> HOLD (fresh hold period).
- DONE:
  - Outputs held.
  - If any stage_ack drops, treat it as a timeout event for the lowest-index dropped stage.
- FAULT:
  - Terminal: stage_rst_n all 0, fault=1, all_ready=0.
  - Exit only via reset_in. lock_in is ignored.
- Lock loss:
  - lock_in=0 sampled in HOLD/RELEASE/WAIT_ACK/DONE -> next cycle stage_rst_n all 0, all_ready=0, state IDLE.
  - retry_cnt is not incremented and not cleared.
  - Lock loss outranks an ack or timeout in the same cycle.
- Simultaneous events:
  - Ack and timeout terminal in the same cycle -> ack wins.
  - reset_in=0 outranks everything.
- Output registers:
  - All outputs registered, no combinational path from inputs.
  - stage_rst_n is monotonic in index: stage k is never released while stage j<k is in reset.
- Widths:
  - Counters sized by $clog2 of their terminal value plus 1 and compared for equality.
  - No wrap: counters saturate and are cleared on state entry.
- retry_cnt clears only on reset_in or on reaching DONE.

Decomposition:
- Package reset_seq_pkg: state enum (IDLE, HOLD, RELEASE, WAIT_ACK, DONE, FAULT), width helper functions for counters.
- One natural sub-module: seq_timer, a loadable saturating down-counter with a terminal flag.
  - Instantiated once and shared between HOLD and WAIT_ACK, since they are mutually exclusive.

Test Plan (NUM_STAGES=3, HOLD_CYCLES=16, ACK_TIMEOUT=32, RETRY_MAX=2):
- Reset then lock_in=1 at cycle 10, each ack raised 3 cycles after its release -> stage_rst_n[0]=1 at cycle 27, [1] at 31, [2] at 35, all_ready=1 at 39.
- stage_ack[1] never asserted -> timeout 32 cycles after stage 1 release; all resets low, retry_cnt=1, rehold. Second timeout -> fault=1, fault_stage=1, retry_cnt=2, stuck until reset_in=0.
- lock_in dropped in WAIT_ACK(1) -> next cycle stage_rst_n=000, state IDLE. Relock resequences from a full 16-cycle hold.
- All acks tied high before lock -> releases one stage per 2 cycles after hold; acks are not sampled before each stage's release.
- In DONE, stage_ack[2] dropped -> resets all low, retry_cnt=1, sequence repeats; on completion retry_cnt=0.
- reset_in=0 for one cycle mid-HOLD and again in FAULT -> all outputs return to reset values on the next edge.
